serial_mag_comp_ctrl: RTL
=========================

Name: serial_mag_comp_ctrl

Overview:
- Multi-cycle sequencer for wide unsigned magnitude comparison.
- Splits two OPW-bit operands into SLICES slices of WIDTH bits each.
- Feeds the slices MSB-first, one per cycle, through a single WIDTH-bit chained comparator slice, carrying the 3-bit {gt,eq,lt} chain result between cycles.
- Sits between a requester (start/done handshake) and the shared comparator slice; replaces a fully unrolled chain of comparators.

Parameters:
- WIDTH, 4, bits per comparator slice.
- SLICES, 4, number of slices; operand width OPW = WIDTH*SLICES (16 by default). Must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  OPW  operand A; captured on accepted start.
- b  input  OPW  operand B; captured on accepted start.
- busy  output  1  high while slices are being processed (RUN).
- done  output  1  one-cycle pulse: result valid.
- result  output  3  {gt,eq,lt}: 100 = a>b, 010 = a==b, 001 = a<b. Held until the next accepted start.
- slice_cnt  output  $clog2(SLICES+1)  number of slices evaluated for the last/current compare.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, result=3'b010, slice_cnt=0, internal operand registers cleared. Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches a and b into a_q and b_q, sets chain=010, idx=SLICES-1, slice_cnt=0, and moves to RUN.
- RUN: busy=1. Each cycle the slice comparator sees a_q[idx*WIDTH +: WIDTH], b_q[idx*WIDTH +: WIDTH] and chain-in=chain.
  - Slice rule: if chain-in != 010, pass chain-in through unchanged. Otherwise output 100, 010 or 001 per unsigned slice compare.
  - On each edge: chain<=slice out, slice_cnt<=slice_cnt+1, idx<=idx-1.
  - When idx==0, go to DONE and load result from the slice output.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - start=1 in the DONE cycle is accepted (DONE->RUN with new operands, same action as IDLE). This gives back-to-back compares with one bubble cycle.
- start while in RUN is ignored; operand inputs are don't-care outside the accept cycle.
- Latency (no early exit): start sampled at edge k; RUN occupies SLICES cycles; done is high in the cycle after edge k+SLICES. slice_cnt=SLICES.
- result and slice_cnt are updated only on entry to DONE; they stay stable through IDLE.
- SLICES=1: a single RUN cycle, then DONE.
- chain is always one-hot; equality is reported only when all slices are equal.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: in RUN, if the slice output != 010, go to DONE immediately and load result with it; slice_cnt reflects the slices actually evaluated (1..SLICES). Minimum latency is 1 RUN cycle.
- Not defined: all SLICES slices are always evaluated; latency is fixed; slice_cnt always equals SLICES. Results are identical in both builds.

Decomposition:
- Shared package: localparams CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, plus the state encoding (IDLE/RUN/DONE, 2 bits).
- One sub-module: mag_comp_slice (parameter WIDTH; inputs a, b, in[2:0]; output out[2:0]). Purely combinational, implementing the slice rule. The controller instantiates it once.

Test Plan (WIDTH=4, SLICES=4):
- a=16'h1234, b=16'h1234, start pulse -> done 5 cycles after start edge, result=010, slice_cnt=4, busy high for exactly 4 cycles.
- a=16'h8000, b=16'h7FFF -> result=100. With SERIAL_CMP_EARLY_EXIT_EN: slice_cnt=1, done 2 cycles after start. Without it: slice_cnt=4, done after 5.
- a=16'h00FE, b=16'h00FF -> result=001, slice_cnt=4 in both builds; then start in the done cycle with a=16'h0001, b=16'h0000 -> result=100, no extra idle cycle.
- Start re-pulsed with a=16'hFFFF, b=0 during RUN of a 16'h0000 vs 16'h0000 compare -> ignored; result=010.
- rst_n=0 for one edge during RUN -> next cycle busy=0, done=0, result=010, slice_cnt=0; no done pulse afterwards.
- Exhaustive sweep of the low slice (a, b in 0..15, upper slices equal) -> result matches the unsigned a<b / a==b / a>b reference for all 256 pairs.

Source files
------------

// File: rtl/serial_mag_comp_ctrl_pkg.sv
// serial_mag_comp_ctrl_pkg
//   Shared definitions for the serial magnitude comparator.
//   - CMP_GT / CMP_EQ / CMP_LT : one-hot {gt,eq,lt} chain codes
//   - state_t                  : controller state encoding (IDLE/RUN/DONE)
package serial_mag_comp_ctrl_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mag_comp_slice.sv
// mag_comp_slice
//   One WIDTH-bit link of an MSB-first magnitude comparator chain.
//   Ports:
//     a, b : slice operands (unsigned)
//     in   : {gt,eq,lt} decision from the more significant slices
//     out  : {gt,eq,lt} decision including this slice
//   A decided chain (in != EQ) passes straight through; only an undecided
//   chain looks at this slice's operands.
module mag_comp_slice
  import serial_mag_comp_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       in,
  output logic [2:0]       out
);

  always_comb begin
    out = in;
    if (in == CMP_EQ) begin
      if (a > b)      out = CMP_GT;
      else if (a < b) out = CMP_LT;
      else            out = CMP_EQ;
    end
  end

endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl
//   Compares two OPW = WIDTH*SLICES bit unsigned operands by walking them
//   MSB-slice first through a single mag_comp_slice, one slice per clock,
//   carrying the {gt,eq,lt} chain in a register between cycles.
//
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : synchronous active-low reset
//     start     : request; accepted only in IDLE or DONE
//     a, b      : operands, captured on an accepted start
//     busy      : high during the RUN cycles
//     done      : one-cycle pulse, result/slice_cnt valid
//     result    : {gt,eq,lt}, held until the next completed compare
//     slice_cnt : slices evaluated for the last compare
//
//   Build option:
//     SERIAL_CMP_EARLY_EXIT_EN - when defined, RUN stops at the first slice
//     that decides the compare; otherwise every slice is always walked and
//     the latency is fixed. The result is the same either way.
//
//   All outputs are registered. Every flop <x>_q is loaded from <x>_d, which
//   the single combinational block below computes.
module serial_mag_comp_ctrl
  import serial_mag_comp_ctrl_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int SLICES = 4,
  localparam int OPW    = WIDTH * SLICES,
  localparam int CW     = $clog2(SLICES + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [2:0]     result,
  output logic [CW-1:0]  slice_cnt
);

  // idx must be at least one bit wide even for SLICES == 1
  localparam int              IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(SLICES - 1);

  state_t          state_q,     state_d;
  logic [OPW-1:0]  a_q,         a_d;
  logic [OPW-1:0]  b_q,         b_d;
  logic [2:0]      chain_q,     chain_d;
  logic [IDXW-1:0] idx_q,       idx_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic            busy_q,      busy_d;
  logic            done_q,      done_d;
  logic [2:0]      result_q,    result_d;
  logic [CW-1:0]   slice_cnt_q, slice_cnt_d;

  logic [WIDTH-1:0] a_sl, b_sl;
  logic [2:0]       slice_out;
  logic             finish;

  // Slice currently under evaluation, MSB slice first
  assign a_sl = a_q[idx_q*WIDTH +: WIDTH];
  assign b_sl = b_q[idx_q*WIDTH +: WIDTH];

  mag_comp_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .in  (chain_q),
    .out (slice_out)
  );

  // Last RUN cycle: the LSB slice, or (with early exit) any decided slice
  always_comb begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish = (idx_q == '0) || (slice_out != CMP_EQ);
`else
    finish = (idx_q == '0);
`endif
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    chain_d     = chain_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    result_d    = result_q;
    slice_cnt_d = slice_cnt_q;

    unique case (state_q)
      // DONE accepts a new start exactly like IDLE, giving back-to-back
      // compares with a single bubble cycle.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          a_d     = a;
          b_d     = b;
          chain_d = CMP_EQ;
          idx_d   = LAST;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // start is ignored here; the operands are already captured
      ST_RUN: begin
        chain_d = slice_out;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q - 1'b1;
        if (finish) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          result_d    = slice_out;
          slice_cnt_d = cnt_q + 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      chain_q     <= CMP_EQ;
      idx_q       <= LAST;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= CMP_EQ;
      slice_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      chain_q     <= chain_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      slice_cnt_q <= slice_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign slice_cnt = slice_cnt_q;

endmodule
